rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Arbiter and sequencer for the register-file write port. Each cycle it selects between the in-order pipeline writeback (the already-muxed DM/WB result) and results returned by the multi-cycle external ALU. External results are buffered in a small FIFO, and the block forces pipeline stalls when that FIFO would otherwise starve or overflow. It also keeps a pending-destination scoreboard that ID uses for hazard detection. It sits between the DM/WB stage and the register file.

## Interface
Parameters:
- DEPTH, 4 — external-result FIFO entries; power of 2, ≥2
- STARVE_MAX, 8 — consecutive unserved cycles of a non-empty FIFO before a forced drain
- AW, 4 — register address width (R0..R15)
- DW, 32 — data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback request
- pipe_dst_addr  in  AW  pipeline destination register
- pipe_data  in  DW  pipeline writeback data
- ext_vld  in  1  external ALU result valid
- ext_rdy  out  1  block accepts an external result this cycle
- ext_dst_addr  in  AW  external result destination
- ext_data  in  DW  external result data
- ext_issue  in  1  ID issued an external-ALU op this cycle
- ext_issue_addr  in  AW  destination of the issued op
- stall_pipe  out  1  pipeline must hold WB; pipe_we ignored
- rf_we  out  1  RF write enable (registered)
- rf_dst_addr  out  AW  RF write address (registered)
- rf_w_data  out  DW  RF write data (registered)
- fifo_cnt  out  log2(DEPTH)+1  FIFO occupancy
- pend_mask  out  2^AW  bit r set = register r awaiting an external result

## Operation
- FIFO stores {addr, data} entries.
- ext_rdy = !rst && (fifo_cnt != DEPTH).
  - A result is accepted when ext_vld && ext_rdy.
  - No accept when full, even if a pop happens in the same cycle.
- force_drain register:
  - Set when fifo_cnt reaches DEPTH or starve_cnt reaches STARVE_MAX.
  - Cleared in the cycle the FIFO becomes empty.
- stall_pipe = force_drain && (fifo_cnt != 0). The output is combinational from registered state.
- Grant priority, evaluated each cycle:
  1. stall_pipe=1: pop the FIFO head to the RF; pipe_we is ignored (the pipeline re-presents it later).
  2. pipe_we=1: pipeline write.
  3. FIFO non-empty: pop head.
  4. Otherwise rf_we=0 next cycle; addr and data hold.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Scoreboard:
  - ext_issue sets pend_mask[ext_issue_addr].
  - An RF write sourced from an external result clears pend_mask[addr] in the cycle the grant is made.
  - Set and clear of the same bit in one cycle: set wins.
- ID must not issue to a register whose pend_mask bit is set. Consequently, external results to the same register never reorder and pipeline writes never overtake older pending external writes.
- Accept and pop in the same cycle: fifo_cnt is unchanged, and the pointers wrap modulo DEPTH.

## Timing
- Grant in cycle N → rf_we/rf_dst_addr/rf_w_data valid in cycle N+1, for exactly one cycle.
- External result accepted in cycle N, FIFO path: earliest grant N+1, RF write visible N+2.
- stall_pipe asserts the cycle after the condition that set force_drain. It stays asserted for fifo_cnt cycles: one pop per cycle, no new pipe grants.
- Values at or after reset:
  - rf_we=0, rf_dst_addr=0, rf_w_data=0.
  - FIFO empty, fifo_cnt=0, pointers=0.
  - force_drain=0, stall_pipe=0, starve_cnt=0, pend_mask=0, ext_rdy=0 during rst.
- Reset mid-operation discards buffered results and clears the scoreboard. The upstream external ALU is reset by the same rst.

## Configuration
- RF_WPORT_BYPASS_EN defined:
  - Condition: FIFO empty, stall_pipe=0, pipe_we=0 and ext_vld=1.
  - The result is granted directly (RF write visible in cycle N+1) and not enqueued. Its pend_mask bit is cleared in the same cycle.
- RF_WPORT_BYPASS_EN undefined: every external result goes through the FIFO; minimum external latency is 2 cycles.

## Test plan
- Reset, then an idle cycle → rf_we=0, pend_mask=0, fifo_cnt=0, ext_rdy=1, stall_pipe=0.
- pipe_we=1, addr 3, data 0x1234 for one cycle → the next cycle shows rf_we=1, rf_dst_addr=3, rf_w_data=0x1234.
- ext_issue addr 5; ext_vld addr 5, data 0xDEAD with pipe idle → RF write visible 2 cycles after accept (1 with RF_WPORT_BYPASS_EN); pend_mask[5] 1→0.
- pipe_we held 1 continuously while 4 external results arrive → FIFO fills; ext_rdy=0; stall_pipe=1 for 4 cycles draining in order; pipeline resumes after.
- pipe_we held 1 and one external result queued → starve_cnt reaches 8; stall_pipe=1 for 1 cycle; the queued result is written.
- Assert rst while fifo_cnt=3 and pend_mask≠0 → the next cycle shows fifo_cnt=0, pend_mask=0, rf_we=0, and no stale write follows.

Source files
------------

// File: rtl/rf_wport_arb.sv
// rf_wport_arb
//   Register-file write-port arbiter. Each cycle it picks one writer for the
//   RF: the in-order pipeline writeback or the head of a small FIFO holding
//   results from the multi-cycle external ALU. When the FIFO fills, or its
//   head has waited STARVE_MAX cycles, the pipeline is stalled until the
//   FIFO is empty. A pending-destination mask lets ID detect hazards on
//   registers that still await an external result.
//
//   Optional feature macro: RF_WPORT_BYPASS_EN. When defined, an external
//   result that arrives while the FIFO is empty and the pipeline is idle is
//   written straight to the RF instead of being enqueued.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   pipe_we/_dst_addr/_data     pipeline writeback request
//   ext_vld/_dst_addr/_data     external ALU result; ext_rdy = accepted
//   ext_issue/_issue_addr       ID issued an external op to this register
//   stall_pipe                  pipeline must hold WB (pipe_we ignored)
//   rf_we/_dst_addr/_w_data     registered RF write port
//   fifo_cnt                    external-result FIFO occupancy
//   pend_mask                   registers awaiting an external result
module rf_wport_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int AW         = 4,
  parameter int DW         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [AW-1:0]          pipe_dst_addr,
  input  logic [DW-1:0]          pipe_data,
  input  logic                   ext_vld,
  output logic                   ext_rdy,
  input  logic [AW-1:0]          ext_dst_addr,
  input  logic [DW-1:0]          ext_data,
  input  logic                   ext_issue,
  input  logic [AW-1:0]          ext_issue_addr,
  output logic                   stall_pipe,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_dst_addr,
  output logic [DW-1:0]          rf_w_data,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [2**AW-1:0]       pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [SW-1:0] ST_LIM   = SW'(STARVE_MAX);
  localparam logic [SW-1:0] ST_ONE   = SW'(1);

  logic [AW+DW-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             force_drain_q, force_drain_d;
  logic [2**AW-1:0] pend_q, pend_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0]    rf_data_q, rf_data_d;

  logic             empty, full, stall, accept, bypass, push, pop;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_FULL);
  assign stall  = force_drain_q && !empty;
  assign accept = ext_vld && ext_rdy;

`ifdef RF_WPORT_BYPASS_EN
  // Stall implies non-empty, so an empty FIFO already excludes a stall.
  assign bypass = accept && empty && !pipe_we;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  // A stall always pops; otherwise the FIFO only gets the port when the
  // pipeline does not want it.
  assign pop  = !empty && (stall || !pipe_we);

  assign {head_addr, head_data} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    starve_d      = starve_q;
    force_drain_d = force_drain_q;
    pend_d        = pend_q;
    rf_we_d       = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_data_d     = rf_data_q;

    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
      rf_we_d           = 1'b1;
      rf_addr_d         = head_addr;
      rf_data_d         = head_data;
      pend_d[head_addr] = 1'b0;
    end else if (pipe_we) begin
      rf_we_d   = 1'b1;
      rf_addr_d = pipe_dst_addr;
      rf_data_d = pipe_data;
    end else if (bypass) begin
      rf_we_d              = 1'b1;
      rf_addr_d            = ext_dst_addr;
      rf_data_d            = ext_data;
      pend_d[ext_dst_addr] = 1'b0;
    end

    // Applied after the clear so a same-cycle set on the same bit wins.
    if (ext_issue) pend_d[ext_issue_addr] = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (empty || pop)         starve_d = '0;
    else if (starve_q != ST_LIM) starve_d = starve_q + ST_ONE;

    // Emptying takes precedence so a drain never outlives its contents.
    if (cnt_d == '0)                      force_drain_d = 1'b0;
    else if (full || starve_q == ST_LIM)  force_drain_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      starve_q      <= '0;
      force_drain_q <= 1'b0;
      pend_q        <= '0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      starve_q      <= starve_d;
      force_drain_q <= force_drain_d;
      pend_q        <= pend_d;
      rf_we_q       <= rf_we_d;
      rf_addr_q     <= rf_addr_d;
      rf_data_q     <= rf_data_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ext_dst_addr, ext_data};
  end

  assign ext_rdy     = !rst && !full;
  assign stall_pipe  = stall;
  assign rf_we       = rf_we_q;
  assign rf_dst_addr = rf_addr_q;
  assign rf_w_data   = rf_data_q;
  assign fifo_cnt    = cnt_q;
  assign pend_mask   = pend_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Testbench for rf_wport_arb: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model of the write port.
module tb_rf_wport_arb;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int AW    = 4;
  localparam int DW    = 32;

`ifdef RF_WPORT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_dst_addr;
  logic [DW-1:0] pipe_data;
  logic          ext_vld, ext_rdy;
  logic [AW-1:0] ext_dst_addr;
  logic [DW-1:0] ext_data;
  logic          ext_issue;
  logic [AW-1:0] ext_issue_addr;
  logic          stall_pipe, rf_we;
  logic [AW-1:0] rf_dst_addr;
  logic [DW-1:0] rf_w_data;
  logic [2:0]    fifo_cnt;
  logic [15:0]   pend_mask;

  rf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(SMAX), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_dst_addr(pipe_dst_addr), .pipe_data(pipe_data),
    .ext_vld(ext_vld), .ext_rdy(ext_rdy), .ext_dst_addr(ext_dst_addr),
    .ext_data(ext_data), .ext_issue(ext_issue), .ext_issue_addr(ext_issue_addr),
    .stall_pipe(stall_pipe), .rf_we(rf_we), .rf_dst_addr(rf_dst_addr),
    .rf_w_data(rf_w_data), .fifo_cnt(fifo_cnt), .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [AW+DW-1:0] mq[$];
  bit               m_fd;
  int               m_starve;
  logic [15:0]      m_pend;
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  bit               m_acc;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ext_rdy",  64'(ext_rdy),     64'(!rst && mq.size() < DEPTH));
    chk("stall",    64'(stall_pipe),  64'(m_fd && mq.size() > 0));
    chk("fifo_cnt", 64'(fifo_cnt),    64'(mq.size()));
    chk("pend",     64'(pend_mask),   64'(m_pend));
    chk("rf_we",    64'(rf_we),       64'(m_we));
    chk("rf_addr",  64'(rf_dst_addr), 64'(m_addr));
    chk("rf_data",  64'(rf_w_data),   64'(m_data));
  endtask

  // Applies the arbitration rules for one clock edge using current inputs.
  task automatic model_edge();
    int n, old_st;
    bit stall, acc, byp, popped;
    logic [AW+DW-1:0] e;
    m_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_fd = 0; m_starve = 0; m_pend = '0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
      return;
    end
    n      = mq.size();
    old_st = m_starve;
    stall  = m_fd && n > 0;
    acc    = ext_vld && n < DEPTH;
    byp    = BYP && acc && n == 0 && !pipe_we;
    popped = 0;
    if (stall || (!pipe_we && n > 0)) begin
      e = mq.pop_front();
      popped = 1;
      m_we = 1'b1; m_addr = e[AW+DW-1:DW]; m_data = e[DW-1:0];
      m_pend[m_addr] = 1'b0;
    end else if (pipe_we) begin
      m_we = 1'b1; m_addr = pipe_dst_addr; m_data = pipe_data;
    end else if (byp) begin
      m_we = 1'b1; m_addr = ext_dst_addr; m_data = ext_data;
      m_pend[ext_dst_addr] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (ext_issue) m_pend[ext_issue_addr] = 1'b1;
    if (acc && !byp) mq.push_back({ext_dst_addr, ext_data});
    m_acc = acc;
    if (n == 0 || popped) m_starve = 0;
    else m_starve = (old_st < SMAX) ? old_st + 1 : SMAX;
    if (mq.size() == 0) m_fd = 0;
    else if (n == DEPTH || old_st == SMAX) m_fd = 1;
  endtask

  // Inputs are driven at posedge+2; outputs checked at posedge+3.
  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_dst_addr = '0; pipe_data = '0;
    ext_vld = 0; ext_dst_addr = '0; ext_data = '0;
    ext_issue = 0; ext_issue_addr = '0;
  endtask

  logic [AW-1:0] outq[$];
  logic [AW-1:0] a;
  int sc;

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #2;
    model_edge();

    // Reset behaviour
    cycle();
    chk("rst_rdy",   64'(ext_rdy), 64'(0));
    chk("rst_cnt",   64'(fifo_cnt), 64'(0));
    chk("rst_we",    64'(rf_we), 64'(0));
    chk("rst_pend",  64'(pend_mask), 64'(0));
    chk("rst_addr",  64'(rf_dst_addr), 64'(0));
    rst = 1'b0;
    #1;
    chk("idle_rdy",  64'(ext_rdy), 64'(1));
    chk("idle_stall", 64'(stall_pipe), 64'(0));
    cycle();
    chk("idle_we",   64'(rf_we), 64'(0));

    // Pipeline write
    pipe_we = 1; pipe_dst_addr = 4'd3; pipe_data = 32'h1234;
    cycle();
    idle_inputs();
    chk("pipe_we",   64'(rf_we), 64'(1));
    chk("pipe_addr", 64'(rf_dst_addr), 64'(3));
    chk("pipe_data", 64'(rf_w_data), 64'(32'h1234));
    cycle();
    chk("pipe_once", 64'(rf_we), 64'(0));

    // External result latency and scoreboard
    ext_issue = 1; ext_issue_addr = 4'd5;
    cycle();
    idle_inputs();
    chk("pend5_set", 64'(pend_mask[5]), 64'(1));
    ext_vld = 1; ext_dst_addr = 4'd5; ext_data = 32'hDEAD;
    cycle();
    idle_inputs();
    if (BYP) begin
      chk("byp_we",    64'(rf_we), 64'(1));
      chk("byp_data",  64'(rf_w_data), 64'(32'hDEAD));
      chk("byp_pend",  64'(pend_mask[5]), 64'(0));
      chk("byp_cnt",   64'(fifo_cnt), 64'(0));
    end else begin
      chk("ext_lat1_we", 64'(rf_we), 64'(0));
      chk("ext_lat1_cnt", 64'(fifo_cnt), 64'(1));
      chk("ext_lat1_pend", 64'(pend_mask[5]), 64'(1));
      cycle();
      chk("ext_we",    64'(rf_we), 64'(1));
      chk("ext_addr",  64'(rf_dst_addr), 64'(5));
      chk("ext_data",  64'(rf_w_data), 64'(32'hDEAD));
      chk("ext_pend",  64'(pend_mask[5]), 64'(0));
    end
    cycle();

    // FIFO fills under continuous pipeline writes, then a forced drain
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1; pipe_dst_addr = 4'd1; pipe_data = 32'(i);
      ext_issue = 1; ext_issue_addr = AW'(8 + i);
      cycle();
    end
    ext_issue = 0;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 32'(100 + i);
      ext_vld = 1; ext_dst_addr = AW'(8 + i); ext_data = 32'hA000 + 32'(i);
      cycle();
    end
    ext_vld = 0;
    #1;
    chk("full_cnt",  64'(fifo_cnt), 64'(4));
    chk("full_rdy",  64'(ext_rdy), 64'(0));
    sc = 0;
    for (int i = 0; i < 8; i++) begin
      pipe_data = 32'(200 + i);
      #1;
      if (stall_pipe) sc++;
      cycle();
    end
    chk("drain_len",   64'(sc), 64'(4));
    chk("drain_done",  64'(fifo_cnt), 64'(0));
    chk("drain_pend",  64'(pend_mask), 64'(0));
    chk("resume_addr", 64'(rf_dst_addr), 64'(1));

    // Starvation forces a single-entry drain
    ext_issue = 1; ext_issue_addr = 4'd12;
    cycle();
    ext_issue = 0;
    ext_vld = 1; ext_dst_addr = 4'd12; ext_data = 32'h5A5A;
    cycle();
    ext_vld = 0;
    sc = 0;
    for (int i = 0; i < 15; i++) begin
      pipe_data = 32'(300 + i);
      #1;
      if (stall_pipe) sc++;
      cycle();
    end
    chk("starve_len",  64'(sc), 64'(1));
    chk("starve_cnt",  64'(fifo_cnt), 64'(0));
    chk("starve_pend", 64'(pend_mask), 64'(0));

    // Reset in the middle of buffered traffic
    for (int i = 0; i < 3; i++) begin
      ext_issue = 1; ext_issue_addr = AW'(2 + i);
      cycle();
    end
    ext_issue = 0;
    for (int i = 0; i < 3; i++) begin
      ext_vld = 1; ext_dst_addr = AW'(2 + i); ext_data = 32'hB000 + 32'(i);
      cycle();
    end
    idle_inputs();
    #1;
    chk("pre_rst_cnt",  64'(fifo_cnt), 64'(3));
    chk("pre_rst_pend", 64'(pend_mask[4:2]), 64'(3'b111));
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_rst_cnt",  64'(fifo_cnt), 64'(0));
    chk("mid_rst_pend", 64'(pend_mask), 64'(0));
    chk("mid_rst_we",   64'(rf_we), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale_we", 64'(rf_we), 64'(0));
    end

    // Randomized traffic with a well-behaved external ALU and ID
    for (int i = 0; i < 800; i++) begin
      pipe_we = ($urandom_range(9, 0) < 6);
      pipe_dst_addr = AW'($urandom_range(15, 0));
      pipe_data = $urandom;
      ext_issue = 0;
      a = AW'($urandom_range(15, 0));
      if ($urandom_range(2, 0) == 0 && !m_pend[a]) begin
        ext_issue = 1; ext_issue_addr = a;
      end
      ext_vld = (outq.size() > 0) && ($urandom_range(1, 0) == 1);
      ext_dst_addr = (outq.size() > 0) ? outq[0] : '0;
      ext_data = $urandom;
      cycle();
      if (m_acc) void'(outq.pop_front());
      if (ext_issue) outq.push_back(ext_issue_addr);
    end
    idle_inputs();
    for (int i = 0; i < 12; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
